mm_match_ctrl: RTL and testbench

//  Controller (initiator side) for an array of MM_DEPTH matching-memory cells. Accepts

---
 rtl/mm_match_ctrl_pkg.sv | 10 +
 rtl/mm_prio_enc.sv | 23 ++
 rtl/mm_match_ctrl.sv | 116 +++++++++++
 tb/tb_mm_match_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mm_match_ctrl_pkg.sv
// mm_match_ctrl_pkg: shared widths and FSM encoding for the matching-memory controller.
package mm_match_ctrl_pkg;
   localparam int MM_KEY_W  = 28;
   localparam int MM_DATA_W = 32;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      EMIT   = 2'd2
   } mm_state_t;
endpackage

// File: rtl/mm_prio_enc.sv
// mm_prio_enc: lowest-set-bit priority encoder giving one-hot, index and any-set flag.
module mm_prio_enc #(
   parameter int W  = 8,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  i_vec,
   output logic [W-1:0]  o_oh,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);
   always_comb begin
      o_oh  = '0;
      o_idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_oh    = '0;
            o_oh[i] = 1'b1;
            o_idx   = IW'(i);
         end
      end
   end
   assign o_any = |i_vec;
endmodule

// File: rtl/mm_match_ctrl.sv
// mm_match_ctrl: initiator-side controller for a matching-memory cell array.
// Presents each token key to all cells; pairs on a hit, stores in the lowest free cell on a miss.
module mm_match_ctrl
   import mm_match_ctrl_pkg::*;
#(
   parameter int MM_DEPTH = 8,
   parameter int MM_IDXW  = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tkn_valid,
   output logic                      tkn_ready,
   input  logic [MM_KEY_W-1:0]       tkn_key,
   input  logic [MM_DATA_W-1:0]      tkn_data,
   output logic [MM_KEY_W-1:0]       mm_key,
   output logic [MM_DATA_W-1:0]      mm_data,
   output logic [MM_DEPTH-1:0]       mm_w_en,
   output logic [MM_DEPTH-1:0]       mm_valid,
   input  logic [MM_DEPTH-1:0]       mm_mtch,
   input  logic [MM_DATA_W*MM_DEPTH-1:0] mm_rd_data,
   output logic                      pr_valid,
   input  logic                      pr_ready,
   output logic [MM_KEY_W-1:0]       pr_key,
   output logic [MM_DATA_W-1:0]      pr_data_a,
   output logic [MM_DATA_W-1:0]      pr_data_b,
   output logic [MM_IDXW:0]          mm_count,
   output logic                      mm_full,
   output logic                      mm_ovf
);
   localparam logic [MM_IDXW:0] ONE  = 1;
   localparam logic [MM_IDXW:0] FULL = (MM_IDXW + 1)'(MM_DEPTH);

   mm_state_t               r_state, w_state;
   logic [MM_KEY_W-1:0]     r_key, r_pr_key;
   logic [MM_DATA_W-1:0]    r_data, r_pr_a, r_pr_b, w_sel_data;
   logic [MM_DEPTH-1:0]     r_valid, w_m_oh, w_f_oh;
   logic [MM_IDXW-1:0]      w_m_idx, w_f_idx;
   logic [MM_IDXW:0]        r_count;
   logic                    r_ovf, w_m_any, w_f_any, w_lookup;

   mm_prio_enc #(.W(MM_DEPTH), .IW(MM_IDXW)) u_match (
      .i_vec(mm_mtch), .o_oh(w_m_oh), .o_idx(w_m_idx), .o_any(w_m_any)
   );
   mm_prio_enc #(.W(MM_DEPTH), .IW(MM_IDXW)) u_free (
      .i_vec(~r_valid), .o_oh(w_f_oh), .o_idx(w_f_idx), .o_any(w_f_any)
   );

   // AND-OR mux of the winning cell's stored data
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < MM_DEPTH; i++)
         w_sel_data = w_sel_data | (mm_rd_data[i*MM_DATA_W +: MM_DATA_W] & {MM_DATA_W{w_m_oh[i]}});
   end

   always_comb begin
      w_state   = r_state;
      tkn_ready = 1'b0;
      mm_w_en   = '0;
      case (r_state)
         IDLE: begin
            tkn_ready = 1'b1;
            if (tkn_valid) w_state = LOOKUP;
         end
         LOOKUP: begin
            w_state = w_m_any ? EMIT : IDLE;
            if (!w_m_any && !mm_full && w_f_any) mm_w_en = w_f_oh;
         end
         EMIT:    if (pr_ready) w_state = IDLE;
         default: w_state = IDLE;
      endcase
   end

   assign w_lookup  = r_state == LOOKUP;
   assign pr_valid  = r_state == EMIT;
   assign mm_full   = r_count == FULL;
   assign mm_key    = r_key;
   assign mm_data   = r_data;
   assign mm_valid  = r_valid;
   assign mm_count  = r_count;
   assign mm_ovf    = r_ovf;
   assign pr_key    = r_pr_key;
   assign pr_data_a = r_pr_a;
   assign pr_data_b = r_pr_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_key    <= '0;
         r_data   <= '0;
         r_pr_key <= '0;
         r_pr_a   <= '0;
         r_pr_b   <= '0;
         r_valid  <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_state;
         if (tkn_ready && tkn_valid) begin
            r_key  <= tkn_key;
            r_data <= tkn_data;
         end
         if (w_lookup && w_m_any) begin
            r_pr_key          <= r_key;
            r_pr_a            <= w_sel_data;
            r_pr_b            <= r_data;
            r_valid[w_m_idx]  <= 1'b0;
            r_count           <= r_count - ONE;
         end else if (w_lookup && !mm_full && w_f_any) begin
            r_valid[w_f_idx]  <= 1'b1;
            r_count           <= r_count + ONE;
         end else if (w_lookup) begin
            r_ovf <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mm_match_ctrl.sv
// tb_mm_match_ctrl: directed self-checking bench with a behavioural cell array beside the controller.
module tb_mm_match_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tkn_valid = 1'b0, tkn_ready;
   logic [27:0]  tkn_key = '0, mm_key, pr_key;
   logic [31:0]  tkn_data = '0, mm_data, pr_data_a, pr_data_b;
   logic [7:0]   mm_w_en, mm_valid, mm_mtch;
   logic [255:0] mm_rd_data;
   logic         pr_valid, pr_ready = 1'b0;
   logic [3:0]   mm_count;
   logic         mm_full, mm_ovf;
   logic [27:0]  cell_key [8];
   logic [31:0]  cell_data[8];
   logic [7:0]   wen;
   int           total = 0, bad = 0;

   always #5 clk = ~clk;

   mm_match_ctrl #(.MM_DEPTH(8), .MM_IDXW(3)) dut (
      .clk(clk), .rst(rst), .tkn_valid(tkn_valid), .tkn_ready(tkn_ready),
      .tkn_key(tkn_key), .tkn_data(tkn_data), .mm_key(mm_key), .mm_data(mm_data),
      .mm_w_en(mm_w_en), .mm_valid(mm_valid), .mm_mtch(mm_mtch), .mm_rd_data(mm_rd_data),
      .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_key(pr_key), .pr_data_a(pr_data_a),
      .pr_data_b(pr_data_b), .mm_count(mm_count), .mm_full(mm_full), .mm_ovf(mm_ovf)
   );

   // Cell array model: storage written on mm_w_en, match qualified by mm_valid
   always @(posedge clk)
      for (int i = 0; i < 8; i++)
         if (mm_w_en[i]) begin
            cell_key[i]  <= mm_key;
            cell_data[i] <= mm_data;
         end
   always_comb begin
      mm_mtch    = '0;
      mm_rd_data = '0;
      for (int i = 0; i < 8; i++) begin
         mm_mtch[i] = mm_valid[i] && (cell_key[i] === mm_key);
         mm_rd_data[i*32 +: 32] = cell_data[i];
      end
   end

   task automatic send(input logic [27:0] k, input logic [31:0] d, output logic [7:0] w);
      @(negedge clk);
      tkn_key = k; tkn_data = d; tkn_valid = 1'b1;
      @(negedge clk);
      w = mm_w_en;
      tkn_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_ready();
      pr_ready = 1'b1;
      @(negedge clk);
      pr_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (mm_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", mm_valid); end
      total++; if (mm_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", mm_count); end
      total++; if ({mm_ovf, pr_valid} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {mm_ovf, pr_valid}); end
      total++; if ({mm_key, mm_data, pr_key, pr_data_a, pr_data_b} !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {mm_key, mm_data, pr_key, pr_data_a, pr_data_b}); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (tkn_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", tkn_ready); end
   endtask

   task automatic test_miss();
      send(28'h0000ABC, 32'h11111111, wen);
      total++; if (wen !== 8'h01) begin bad++; $display("FAIL miss_wen got=%h exp=01", wen); end
      total++; if (mm_valid !== 8'h01) begin bad++; $display("FAIL miss_valid got=%h exp=01", mm_valid); end
      total++; if (mm_count !== 4'd1) begin bad++; $display("FAIL miss_count got=%0d exp=1", mm_count); end
      total++; if (pr_valid !== 1'b0) begin bad++; $display("FAIL miss_prvalid got=%b exp=0", pr_valid); end
   endtask

   task automatic test_hit_hold();
      @(negedge clk);
      tkn_key = 28'h0000ABC; tkn_data = 32'h22222222; tkn_valid = 1'b1;
      @(negedge clk);
      tkn_valid = 1'b0;
      total++; if ({mm_w_en, pr_valid, tkn_ready} !== 10'b0) begin bad++; $display("FAIL hit_lookup got=%h exp=0", {mm_w_en, pr_valid, tkn_ready}); end
      @(negedge clk);
      total++; if (pr_valid !== 1'b1) begin bad++; $display("FAIL hit_prvalid got=%b exp=1", pr_valid); end
      total++; if ({pr_key, pr_data_a, pr_data_b} !== {28'h0000ABC, 32'h11111111, 32'h22222222}) begin bad++; $display("FAIL hit_pair got=%h_%h_%h exp=0000abc_11111111_22222222", pr_key, pr_data_a, pr_data_b); end
      total++; if ({mm_valid, mm_count} !== 12'h000) begin bad++; $display("FAIL hit_free got=%h/%0d exp=00/0", mm_valid, mm_count); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++; if ({pr_valid, tkn_ready, pr_data_a, pr_data_b} !== {2'b10, 32'h11111111, 32'h22222222}) begin bad++; $display("FAIL hold_%0d got=%b%b_%h_%h exp=10_11111111_22222222", c, pr_valid, tkn_ready, pr_data_a, pr_data_b); end
      end
      pulse_ready();
      total++; if ({pr_valid, tkn_ready} !== 2'b01) begin bad++; $display("FAIL release got=%b exp=01", {pr_valid, tkn_ready}); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         send(28'h100 + 28'(i), 32'hD0000000 + 32'(i), wen);
         total++; if (wen !== 8'(1 << i)) begin bad++; $display("FAIL fill_wen_%0d got=%h exp=%h", i, wen, 8'(1 << i)); end
      end
      total++; if ({mm_full, mm_count, mm_ovf} !== {1'b1, 4'd8, 1'b0}) begin bad++; $display("FAIL full_state got=%b/%0d/%b exp=1/8/0", mm_full, mm_count, mm_ovf); end
      send(28'h200, 32'hEEEEEEEE, wen);
      total++; if (wen !== 8'h00) begin bad++; $display("FAIL ovf_wen got=%h exp=00", wen); end
      total++; if ({mm_ovf, mm_count, mm_valid} !== {1'b1, 4'd8, 8'hFF}) begin bad++; $display("FAIL ovf_state got=%b/%0d/%h exp=1/8/ff", mm_ovf, mm_count, mm_valid); end
      send(28'h100, 32'h0000CAFE, wen);
      total++; if ({pr_valid, pr_data_a, pr_data_b} !== {1'b1, 32'hD0000000, 32'h0000CAFE}) begin bad++; $display("FAIL full_hit got=%b_%h_%h exp=1_d0000000_0000cafe", pr_valid, pr_data_a, pr_data_b); end
      pulse_ready();
      total++; if ({mm_ovf, mm_full, mm_count, mm_valid} !== {2'b10, 4'd7, 8'hFE}) begin bad++; $display("FAIL ovf_sticky got=%b%b/%0d/%h exp=10/7/fe", mm_ovf, mm_full, mm_count, mm_valid); end
   endtask

   task automatic test_reuse();
      do_reset();
      for (int i = 0; i < 4; i++) send(28'h300 + 28'(i), 32'hA0000000 + 32'(i), wen);
      send(28'h301, 32'h0BADF00D, wen);
      total++; if ({pr_key, pr_data_a, pr_data_b} !== {28'h301, 32'hA0000001, 32'h0BADF00D}) begin bad++; $display("FAIL reuse_pair got=%h_%h_%h exp=0000301_a0000001_0badf00d", pr_key, pr_data_a, pr_data_b); end
      pulse_ready();
      total++; if ({mm_valid, mm_count} !== {8'h0D, 4'd3}) begin bad++; $display("FAIL reuse_freed got=%h/%0d exp=0d/3", mm_valid, mm_count); end
      send(28'h400, 32'h44444444, wen);
      total++; if (wen !== 8'h02) begin bad++; $display("FAIL reuse_wen got=%h exp=02", wen); end
      total++; if (mm_valid !== 8'h0F) begin bad++; $display("FAIL reuse_valid got=%h exp=0f", mm_valid); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 3; i++) send(28'h500 + 28'(i), 32'hB0000000 + 32'(i), wen);
      send(28'h501, 32'h55555555, wen);
      total++; if ({pr_valid, mm_count} !== {1'b1, 4'd2}) begin bad++; $display("FAIL pre_rst got=%b/%0d exp=1/2", pr_valid, mm_count); end
      #2 rst = 1'b0;
      #1;
      total++; if ({pr_valid, mm_valid, mm_count} !== 13'b0) begin bad++; $display("FAIL async_rst got=%b/%h/%0d exp=0/00/0", pr_valid, mm_valid, mm_count); end
      @(negedge clk);
      rst = 1'b1;
      send(28'h500, 32'h66666666, wen);
      total++; if ({wen, pr_valid, mm_valid} !== {8'h01, 1'b0, 8'h01}) begin bad++; $display("FAIL post_rst_miss got=%h/%b/%h exp=01/0/01", wen, pr_valid, mm_valid); end
   endtask

   initial begin
      test_reset();
      test_miss();
      test_hit_hold();
      test_full();
      test_reuse();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
